seg7_scan_decoder: RTL

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder_if.sv | 21 ++
 rtl/seg7_scan_decoder.sv | 119 +++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Bus bundle between a multiplexed 7-segment scan source and its decoder.
// Master drives segments and digit selects; slave returns decoded digits.
interface seg7_scan_decoder_if;
    logic [6:0]  Seg;
    logic [3:0]  An;
    logic        err_clr;
    logic [15:0] BCD;
    logic [3:0]  Valid;
    logic        upd;
    logic        Err;

    modport master (
        output Seg, An, err_clr,
        input  BCD, Valid, upd, Err
    );

    modport slave (
        input  Seg, An, err_clr,
        output BCD, Valid, upd, Err
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Debounced decoder of a scanned 7-segment display back into BCD digits.
// SEG7_BLANK_EN: treat the all-dark pattern as a legal blank digit (0xA).
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_decoder_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [7:0] LIM     = 8'(STABLE_CYC);
    localparam logic [7:0] LIM_M1  = 8'(STABLE_CYC - 1);

    logic [10:0] r_smp;
    logic [7:0]  r_cnt;
    logic [1:0]  r_state;
    logic [15:0] r_bcd;
    logic [3:0]  r_valid;
    logic        r_upd;
    logic        r_err;

    logic [10:0] w_in;
    logic        w_same;
    logic        w_in_oh;
    logic        w_cap;
    logic [3:0]  w_val;
    logic        w_legal;
    logic        w_blank;
    logic        w_illegal;
    logic        w_chg;

    assign w_in      = {bus.An, bus.Seg};
    assign w_same    = (w_in == r_smp);
    assign w_in_oh   = $onehot(bus.An);
    assign w_cap     = (r_state == S_TRACK) && w_same && (r_cnt == LIM_M1);
    assign w_illegal = !w_legal && !w_blank;

    always_comb begin
        w_val   = 4'hF;
        w_legal = 1'b0;
        w_blank = 1'b0;
        case (r_smp[6:0])
            7'b1111110: begin w_val = 4'd0; w_legal = 1'b1; end
            7'b0110000: begin w_val = 4'd1; w_legal = 1'b1; end
            7'b1101101: begin w_val = 4'd2; w_legal = 1'b1; end
            7'b1111001: begin w_val = 4'd3; w_legal = 1'b1; end
            7'b0110011: begin w_val = 4'd4; w_legal = 1'b1; end
            7'b1011011: begin w_val = 4'd5; w_legal = 1'b1; end
            7'b1011111: begin w_val = 4'd6; w_legal = 1'b1; end
            7'b1110000: begin w_val = 4'd7; w_legal = 1'b1; end
            7'b1111111: begin w_val = 4'd8; w_legal = 1'b1; end
            7'b1111011: begin w_val = 4'd9; w_legal = 1'b1; end
`ifdef SEG7_BLANK_EN
            7'b0000000: begin w_val = 4'hA; w_blank = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Pulse only when the selected digit's stored value or validity moves
    always_comb begin
        w_chg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r_smp[7+i]) begin
                w_chg = (r_bcd[4*i +: 4] != w_val) || (r_valid[i] != w_legal);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_smp   <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
        end else if (!w_same) begin
            r_smp   <= w_in;
            r_cnt   <= '0;
            r_state <= w_in_oh ? S_TRACK : S_IDLE;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (r_cnt != LIM) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_cap) begin
                r_state <= S_HOLD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd   <= 16'hFFFF;
            r_valid <= '0;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_upd <= w_cap && w_chg;
            for (int i = 0; i < 4; i++) begin
                if (w_cap && r_smp[7+i]) begin
                    r_bcd[4*i +: 4] <= w_val;
                    r_valid[i]      <= w_legal;
                end
            end
            if (w_cap && w_illegal) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.BCD   = r_bcd;
    assign bus.Valid = r_valid;
    assign bus.upd   = r_upd;
    assign bus.Err   = r_err;
endmodule
